// File: rtl/arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package arb_pkg;

  // Arbiter transaction states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Requester identifiers
  localparam logic REQ_CORE  = 1'b0;
  localparam logic REQ_ACCEL = 1'b1;

  // Width of the performance counters
  localparam int CNT_WIDTH = 32;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // Select the winner among the active requesters
  always_comb begin
    valid  = |req;
    winner = req[1] ? REQ_ACCEL : REQ_CORE;
    if (req == 2'b11) begin
      winner = (last == REQ_CORE) ? REQ_ACCEL : REQ_CORE;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-ported data memory between the core memory unit
// (requester 0) and the accelerator (requester 1). One transaction at a time,
// round-robin on ties, registered memory-side outputs and a one-cycle done
// pulse with read data back to the owner.
module data_mem_arbiter
  import arb_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    c_req,
  input  logic                    c_we,
  input  logic [ADDRESS_BITS-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0]   c_wdata,
  output logic                    c_done,
  output logic [DATA_WIDTH-1:0]   c_rdata,
  output logic                    c_busy,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDRESS_BITS-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic                    a_done,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_busy,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    report
);

  arb_state_t              state_reg;
  logic                    owner_reg;
  logic                    last_reg;
  logic                    we_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    mem_req_reg;

  logic [CNT_WIDTH-1:0]    c_grants_reg;
  logic [CNT_WIDTH-1:0]    a_grants_reg;
  logic [CNT_WIDTH-1:0]    conflict_cycles_reg;

  logic [1:0]              req_vec;
  logic [1:0]              busy_vec;
  logic                    pick_valid;
  logic                    pick_winner;
  logic                    sel_we;
  logic [ADDRESS_BITS-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    finish_now;

  assign req_vec = {a_req, c_req};

  rr_pick2 u_pick (
    .req    (req_vec),
    .last   (last_reg),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign sel_we    = (pick_winner == REQ_ACCEL) ? a_we    : c_we;
  assign sel_addr  = (pick_winner == REQ_ACCEL) ? a_addr  : c_addr;
  assign sel_wdata = (pick_winner == REQ_ACCEL) ? a_wdata : c_wdata;

  // The transaction completes on this edge: write accepted or read data back.
  // A stray mem_rvalid outside WAIT_RD never reaches here.
  assign finish_now = ((state_reg == ISSUE) && mem_ready && we_q) ||
                      ((state_reg == WAIT_RD) && mem_rvalid);

  // Memory-side outputs come straight from the latched request registers
  assign mem_req   = mem_req_reg;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Transaction FSM: arbitrate in IDLE, hold the request in ISSUE, wait for
  // read data, then one DONE cycle before the port is free again
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      owner_reg   <= REQ_CORE;
      last_reg    <= REQ_ACCEL;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_req_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            owner_reg   <= pick_winner;
            we_q        <= sel_we;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            mem_req_reg <= 1'b1;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req_reg <= 1'b0;
            state_reg   <= we_q ? DONE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (mem_rvalid) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          last_reg  <= owner_reg;
          state_reg <= IDLE;
        end
        default: begin
          mem_req_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  // Per-requester busy flag and registered completion pulse with read data
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic                  done_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  owns;

    assign owns         = (state_reg != IDLE) && (owner_reg == 1'(gi));
    assign busy_vec[gi] = req_vec[gi] & ~owns;

    // Pulse done for exactly the DONE cycle; read data is zero for writes
    always_ff @(posedge clock) begin
      if (!reset) begin
        done_q  <= 1'b0;
        rdata_q <= '0;
      end else if (finish_now && (owner_reg == 1'(gi))) begin
        done_q  <= 1'b1;
        rdata_q <= we_q ? '0 : mem_rdata;
      end else begin
        done_q  <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  assign c_done  = g_port[0].done_q;
  assign c_rdata = g_port[0].rdata_q;
  assign c_busy  = busy_vec[0];
  assign a_done  = g_port[1].done_q;
  assign a_rdata = g_port[1].rdata_q;
  assign a_busy  = busy_vec[1];

  // Performance counters: grants per requester and cycles with someone stalled
  always_ff @(posedge clock) begin
    if (!reset) begin
      c_grants_reg        <= '0;
      a_grants_reg        <= '0;
      conflict_cycles_reg <= '0;
    end else begin
      if (state_reg == DONE) begin
        if (owner_reg == REQ_ACCEL) begin
          a_grants_reg <= a_grants_reg + 1'b1;
        end else begin
          c_grants_reg <= c_grants_reg + 1'b1;
        end
      end
      if (|busy_vec) begin
        conflict_cycles_reg <= conflict_cycles_reg + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Print the counters on every cycle that report is held high
  always_ff @(posedge clock) begin
    if (reset && report) begin
      $display("data_mem_arbiter core %0d: c_grants=%0d a_grants=%0d conflict_cycles=%0d",
               CORE, c_grants_reg, a_grants_reg, conflict_cycles_reg);
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus pushes expected memory
// requests and completions; a memory model and a done monitor pop and compare.
module tb_data_mem_arbiter;
  import arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, a_req, a_we;
  logic [19:0] c_addr, a_addr;
  logic [31:0] c_wdata, a_wdata;
  logic        c_done, a_done, c_busy, a_busy;
  logic [31:0] c_rdata, a_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        report;

  typedef struct {logic who; logic [31:0] rdata; int cyc;} done_t;
  typedef struct {logic we; logic [19:0] addr; logic [31:0] wdata;} mreq_t;

  done_t exp_done[$];
  mreq_t exp_mem[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base;
  int ready_delay = 0;
  int rvalid_delay = 1;
  int wait_cnt = 0;
  int rd_cnt = 0;
  bit rd_pend = 0;
  logic [31:0] rd_data = '0;

  data_mem_arbiter #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_done(c_done), .c_rdata(c_rdata), .c_busy(c_busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata), .a_busy(a_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .report(report)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_mem(input logic we, input logic [19:0] addr, input logic [31:0] wdata);
    mreq_t m;
    m.we = we; m.addr = addr; m.wdata = wdata;
    exp_mem.push_back(m);
  endtask

  task automatic push_done(input logic who, input logic [31:0] rdata, input int at);
    done_t d;
    d.who = who; d.rdata = rdata; d.cyc = at;
    exp_done.push_back(d);
  endtask

  task automatic check_counters(input string tag, input int cg, input int ag, input int cc, input logic lst);
    chk({tag, "_c_grants"}, dut.c_grants_reg, cg);
    chk({tag, "_a_grants"}, dut.a_grants_reg, ag);
    chk({tag, "_conflict"}, dut.conflict_cycles_reg, cc);
    chk({tag, "_last"}, dut.last_reg, lst);
  endtask

  // Core requester: one transaction, optionally keeping req high afterwards
  task automatic c_txn(input logic we, input logic [19:0] addr, input logic [31:0] wdata, input bit keep);
    bit seen;
    seen = 0;
    c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (c_done) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL c_txn_timeout actual=no_done required=done addr=%h", addr);
    end
    @(posedge clk); #1;
    if (!keep) c_req = 1'b0;
  endtask

  // Accelerator requester: same protocol as the core
  task automatic a_txn(input logic we, input logic [19:0] addr, input logic [31:0] wdata, input bit keep);
    bit seen;
    seen = 0;
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (a_done) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL a_txn_timeout actual=no_done required=done addr=%h", addr);
    end
    @(posedge clk); #1;
    if (!keep) a_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; c_req = 1'b0; a_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Memory model: accepts after ready_delay cycles, returns read data
  // rvalid_delay cycles after acceptance; checks every presented request
  initial begin
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (rd_pend) begin
        if (rd_cnt == rvalid_delay - 1) begin
          mem_rvalid = 1'b1; mem_rdata = rd_data; rd_pend = 0;
        end else begin
          rd_cnt++;
        end
      end
      if (mem_req === 1'b1) begin
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected actual=req addr=%h required=no_req", mem_addr);
        end else begin
          chk("mem_we", mem_we, exp_mem[0].we);
          chk("mem_addr", mem_addr, exp_mem[0].addr);
          chk("mem_wdata", mem_wdata, exp_mem[0].wdata);
        end
        if (wait_cnt == ready_delay) begin
          mem_ready = 1'b1; wait_cnt = 0;
          if (exp_mem.size() > 0) void'(exp_mem.pop_front());
          if (!mem_we) begin
            rd_pend = 1; rd_cnt = 0;
            rd_data = (mem_addr == 20'h00010) ? 32'hDEADBEEF : {12'hACC, mem_addr};
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Done monitor: every pulse must match the head of the expected queue
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (c_done === 1'b1 || a_done === 1'b1) begin
        chk("done_onehot", {c_done, a_done} == 2'b11, 1'b0);
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected actual=c%0b/a%0b required=none", c_done, a_done);
        end else begin
          e = exp_done.pop_front();
          $display("done: who=%0d rdata=%h cycle=%0d", a_done, a_done ? a_rdata : c_rdata, cyc);
          chk("done_who", a_done, e.who);
          chk("done_rdata", a_done ? a_rdata : c_rdata, e.rdata);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; report = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 20'h0);
    chk("rst_c_done", c_done, 1'b0);
    chk("rst_a_done", a_done, 1'b0);
    chk("rst_state", 32'(dut.state_reg), 32'(IDLE));
    check_counters("rst", 0, 0, 0, 1'b1);

    // Simultaneous: core write 0x5 wins the first tie, accel read follows
    @(posedge clk); #1; base = cyc;
    push_mem(1'b1, 20'h00020, 32'h5);
    push_mem(1'b0, 20'h00040, 32'h0);
    push_done(1'b0, 32'h0, base + 2);
    push_done(1'b1, 32'hACC00040, base + 6);
    fork
      c_txn(1'b1, 20'h00020, 32'h5, 0);
      a_txn(1'b0, 20'h00040, 32'h0, 0);
      begin
        for (int k = 0; k <= 6; k++) begin
          @(negedge clk);
          chk($sformatf("sim_a_busy_c%0d", k), a_busy, (k <= 3) ? 1'b1 : 1'b0);
        end
      end
    join
    check_counters("sim", 1, 1, 4, 1'b1);

    // Core read alone from 0x00010
    @(posedge clk); #1; base = cyc;
    push_mem(1'b0, 20'h00010, 32'h0);
    push_done(1'b0, 32'hDEADBEEF, base + 3);
    c_txn(1'b0, 20'h00010, 32'h0, 0);
    check_counters("solo", 2, 1, 5, 1'b0);

    // Repeated contention: both hold req for three transactions each
    do_reset();
    @(posedge clk); #1; base = cyc;
    for (int k = 0; k < 3; k++) begin
      push_mem(1'b1, 20'h00100 + 20'(k), 32'hC0 + 32'(k));
      push_mem(1'b0, 20'h00200 + 20'(k), 32'h0);
    end
    push_done(1'b0, 32'h0, base + 2);
    push_done(1'b1, 32'hACC00200, base + 6);
    push_done(1'b0, 32'h0, base + 9);
    push_done(1'b1, 32'hACC00201, base + 13);
    push_done(1'b0, 32'h0, base + 16);
    push_done(1'b1, 32'hACC00202, base + 20);
    fork
      for (int k = 0; k < 3; k++) c_txn(1'b1, 20'h00100 + 20'(k), 32'hC0 + 32'(k), k < 2);
      for (int k = 0; k < 3; k++) a_txn(1'b0, 20'h00200 + 20'(k), 32'h0, k < 2);
    join
    check_counters("rr", 3, 3, 18, 1'b1);

    // Report pulse
    @(posedge clk); #1 report = 1'b1;
    @(posedge clk); #1 report = 1'b0;

    // Back-pressure: mem_ready held low 4 cycles per request, accel waits
    ready_delay = 4;
    @(posedge clk); #1; base = cyc;
    push_mem(1'b1, 20'h00333, 32'hCAFEF00D);
    push_mem(1'b0, 20'h00555, 32'h0);
    push_done(1'b0, 32'h0, base + 6);
    push_done(1'b1, 32'hACC00555, base + 14);
    fork
      c_txn(1'b1, 20'h00333, 32'hCAFEF00D, 0);
      a_txn(1'b0, 20'h00555, 32'h0, 0);
    join
    check_counters("bp", 4, 4, 26, 1'b1);
    ready_delay = 0;

    // Reset in WAIT_RD, stale rvalid arrives after release
    rvalid_delay = 5;
    @(posedge clk); #1; base = cyc;
    push_mem(1'b0, 20'h00444, 32'h0);
    c_req = 1'b1; c_we = 1'b0; c_addr = 20'h00444; c_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_state_before", 32'(dut.state_reg), 32'(WAIT_RD));
    reset = 1'b0; c_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_state", 32'(dut.state_reg), 32'(IDLE));
    chk("midrst_mem_req", mem_req, 1'b0);
    check_counters("midrst", 0, 0, 0, 1'b1);
    rvalid_delay = 1;

    repeat (2) @(posedge clk);
    chk("exp_done_drained", exp_done.size(), 0);
    chk("exp_mem_drained", exp_mem.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-ported data memory between the core's memory unit (requester 0) and the accelerator (requester 1). It accepts at most one transaction at a time and arbitrates round-robin when both request together. It drives the memory port with registered outputs and returns a one-cycle completion pulse, with read data, to the owning requester. It sits between `memory_unit`/`Accel` and the data cache/BRAM port, and keeps per-requester performance counters that print on `report`.

## Interface
- `CORE`, 0: core ID, used only in report output.
- `DATA_WIDTH`, 32: data word width.
- `ADDRESS_BITS`, 20: word/byte address width, passed through unchanged.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on rising `clock`; 0 = reset).
- `c_req`, `a_req`  in  1 each  core / accel request; held high until that requester's `*_done`.
- `c_we`, `a_we`  in  1 each  1 = write, 0 = read.
- `c_addr`, `a_addr`  in  ADDRESS_BITS each  request address.
- `c_wdata`, `a_wdata`  in  DATA_WIDTH each  write data.
- `c_done`, `a_done`  out  1 each  one-cycle completion pulse.
- `c_rdata`, `a_rdata`  out  DATA_WIDTH each  read data, valid only while the matching `*_done` is high.
- `c_busy`, `a_busy`  out  1 each  high while the requester has a request pending but does not own the port. The core uses this as a stall.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  ADDRESS_BITS  memory address.
- `mem_wdata`  out  DATA_WIDTH  write data.
- `mem_ready`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  DATA_WIDTH  read data.
- `report`  in  1  print counters.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE: any `req` is high. The winner's `we`, `addr` and `wdata` are latched into `owner`, `we_q`, `addr_q` and `wdata_q`.
  - ISSUE: `mem_req` = 1 and the `mem_*` outputs come from the latched registers.
    - `mem_ready` = 1 with `we_q` = 1 → DONE.
    - `mem_ready` = 1 with `we_q` = 0 → WAIT_RD.
    - `mem_ready` = 0 → stay in ISSUE, outputs unchanged.
  - WAIT_RD: `mem_req` = 0. On `mem_rvalid`, capture `mem_rdata` and go to DONE.
  - DONE: the owner's `*_done` = 1 and its `*_rdata` = captured data (0 for writes). `last` ← `owner`, then return to IDLE. No arbitration happens in DONE.
- Arbitration in IDLE:
  - Only one `req` high: that requester wins.
  - Both high: the requester ≠ `last` wins.
  - `last` resets to 1, so the core wins the first tie.
- The requester must drop `req` on the clock edge that ends its `done` cycle. If `req` is still high in the following IDLE cycle, it is a new request.
- `busy_x` = `req_x` & !(state ≠ IDLE & `owner` == x & state ∈ {ISSUE, WAIT_RD, DONE}).
- `mem_rvalid` outside WAIT_RD is ignored. This covers stale responses after a reset.
- Counters (32-bit, wrap, reset to 0):
  - `c_grants` and `a_grants` increment on each DONE.
  - `conflict_cycles` increments on every cycle where a requester's `busy` is high.
- When `report` = 1, the block `$display`s the core ID and the three counters once per cycle that `report` is high.

## Timing
- Reset (`reset` = 0 at an edge): state = IDLE, `last` = 1, counters = 0.
  - Outputs: all `*_done`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `*_rdata` = 0.
  - A reset during ISSUE or WAIT_RD aborts the transaction. No `done` is issued.
- All `mem_*` and `*_done`/`*_rdata` outputs are registered.
- Read with `mem_ready` = 1 in its first cycle and `mem_rvalid` one cycle later:
  - `req` sampled at edge 0, `mem_req` high in cycle 1, `done` high in cycle 3.
  - The port is free for a new arbitration at cycle 4.
- Write with immediate `mem_ready`: `done` in cycle 2, next arbitration in cycle 3.
- Each extra cycle of `mem_ready` low or `mem_rvalid` delay adds one cycle.
- Back-to-back with both requesting: grants alternate core, accel, core, … Neither requester waits more than one foreign transaction.

## Structure
- Package `arb_pkg`:
  - State enum: IDLE, ISSUE, WAIT_RD, DONE.
  - Requester ID constants: `REQ_CORE` = 0, `REQ_ACCEL` = 1.
  - Counter width constant: 32.
- Sub-module `rr_pick2`: combinational two-way round-robin picker. Inputs are `req[1:0]` and `last`; outputs are `valid` and `winner`. It is instantiated once.

## Test plan
- Core read alone:
  - Stimulus: addr 0x00010, memory returns 0xDEADBEEF one cycle after ready.
  - Response: `c_done` in cycle 3 with `c_rdata` = 0xDEADBEEF; `a_done` never pulses.
- Simultaneous requests:
  - Stimulus: core write 0x5 and accel read both raised at cycle 0.
  - Response: the core is served first and `a_busy` = 1 until the accel is issued. Then the accel is served, and `last` ends at 1.
- Repeated contention:
  - Stimulus: both requesters hold `req` continuously for 6 transactions.
  - Response: grants strictly alternate; `c_grants` = `a_grants` = 3.
- Memory back-pressure:
  - Stimulus: `mem_ready` held low for 4 cycles.
  - Response: `mem_addr`/`mem_wdata` stay stable, `done` is delayed by exactly 4 cycles, and `conflict_cycles` counts the waiting requester.
- Reset mid-operation:
  - Stimulus: `reset` = 0 in WAIT_RD, then `mem_rvalid` pulses after reset releases.
  - Response: no `done`, state is IDLE, counters are 0, and the stale data is ignored.
- `report` pulse after the contention run: the display shows counters 3/3 and a nonzero `conflict_cycles`.
